// File: rtl/button_conditioner_if.sv
// Button/processor signal bundle for the button conditioner.
// master drives the raw buttons and acknowledge; slave is the conditioner.
interface button_conditioner_if;
   logic       up;
   logic       down;
   logic       jump_ack;
   logic       io_jump;
   logic       jump_pulse;
   logic       duck;
   logic [7:0] jump_count;

   modport master (
      output up, down, jump_ack,
      input  io_jump, jump_pulse, duck, jump_count
   );

   modport slave (
      input  up, down, jump_ack,
      output io_jump, jump_pulse, duck, jump_count
   );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces the up/down buttons, then derives a latched jump request,
// a one-cycle jump strobe, a press counter and a duck level with jump priority.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input logic                  clock,
   input logic                  reset,
   button_conditioner_if.slave  bus
);

   localparam logic [19:0] CntLast = 20'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {LowStable, RiseWait, HighStable, FallWait} state_e;

   // Index 0 is the up button, index 1 is the down button.
   logic [1:0]  sync1_q, sync2_q;
   state_e      state_q [2];
   state_e      state_d [2];
   logic [19:0] cnt_q [2];
   logic [19:0] cnt_d [2];
   logic [1:0]  stable, stable_d;

   logic       jump_pulse_q, jump_pulse_d;
   logic       io_jump_q, io_jump_d;
   logic       duck_q, duck_d;
   logic [7:0] jump_count_q, jump_count_d;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            LowStable: begin
               if (sync2_q[i]) begin
                  state_d[i] = RiseWait;
                  cnt_d[i]   = 20'd1;
               end
            end
            RiseWait: begin
               if (!sync2_q[i]) begin
                  state_d[i] = LowStable;
                  cnt_d[i]   = 20'd0;
               end else if (cnt_q[i] == CntLast) begin
                  state_d[i] = HighStable;
                  cnt_d[i]   = 20'd0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 20'd1;
               end
            end
            HighStable: begin
               if (!sync2_q[i]) begin
                  state_d[i] = FallWait;
                  cnt_d[i]   = 20'd1;
               end
            end
            FallWait: begin
               if (sync2_q[i]) begin
                  state_d[i] = HighStable;
                  cnt_d[i]   = 20'd0;
               end else if (cnt_q[i] == CntLast) begin
                  state_d[i] = LowStable;
                  cnt_d[i]   = 20'd0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 20'd1;
               end
            end
         endcase
         stable[i]   = (state_q[i] == HighStable) || (state_q[i] == FallWait);
         stable_d[i] = (state_d[i] == HighStable) || (state_d[i] == FallWait);
      end
   end

   // The strobe looks at the next debounced level so it lands on the same edge as the flip.
   always_comb begin
      jump_pulse_d = stable_d[0] & ~stable[0];
      io_jump_d    = io_jump_q;
      if (jump_pulse_d) begin
         io_jump_d = 1'b1;
      end else if (bus.jump_ack) begin
         io_jump_d = 1'b0;
      end
      jump_count_d = jump_pulse_d ? jump_count_q + 8'd1 : jump_count_q;
      duck_d       = stable[1] & ~stable[0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q      <= 2'b00;
         sync2_q      <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= LowStable;
            cnt_q[i]   <= 20'd0;
         end
         jump_pulse_q <= 1'b0;
         io_jump_q    <= 1'b0;
         duck_q       <= 1'b0;
         jump_count_q <= 8'd0;
      end else begin
         sync1_q      <= {bus.down, bus.up};
         sync2_q      <= sync1_q;
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         jump_pulse_q <= jump_pulse_d;
         io_jump_q    <= io_jump_d;
         duck_q       <= duck_d;
         jump_count_q <= jump_count_d;
      end
   end

   assign bus.jump_pulse = jump_pulse_q;
   assign bus.io_jump    = io_jump_q;
   assign bus.duck       = duck_q;
   assign bus.jump_count = jump_count_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4: expected jump strobes are
// queued by the stimulus and popped by a monitor whenever jump_pulse is seen.
module tb_button_conditioner;

   typedef struct {
      int edge_no;
      int count;
   } exp_t;

   logic clock;
   logic reset;
   int   edge_cnt;
   int   total;
   int   bad;
   int   pulses;
   exp_t sb[$];
   exp_t e;

   button_conditioner_if bus ();

   button_conditioner #(
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial edge_cnt = 0;
   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s at edge %0d: got %0d, required %0d", name, edge_cnt, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk_outs(input string tag, input int p, input int j, input int d, input int c);
      chk({tag, "_jump_pulse"}, int'(bus.jump_pulse), p);
      chk({tag, "_io_jump"}, int'(bus.io_jump), j);
      chk({tag, "_duck"}, int'(bus.duck), d);
      chk({tag, "_jump_count"}, int'(bus.jump_count), c);
   endtask

   task automatic expect_pulse(input int at, input int cnt);
      exp_t x;
      x.edge_no = at;
      x.count   = cnt;
      sb.push_back(x);
   endtask

   // Every strobe must match the head of the scoreboard in both timing and count value.
   task automatic monitor();
      forever begin
         @(negedge clock);
         if (bus.jump_pulse === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_pulse: got pulse at edge %0d, required none", edge_cnt);
            end else begin
               e = sb.pop_front();
               chk("pulse_edge", edge_cnt, e.edge_no);
               chk("pulse_count", int'(bus.jump_count), e.count);
            end
         end
      end
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      bus.up       = 1'b0;
      bus.down     = 1'b0;
      bus.jump_ack = 1'b0;
      step(2);
      chk_outs("in_reset", 0, 0, 0, 0);
      reset = 1'b0;
      step(1);
      chk_outs("after_reset", 0, 0, 0, 0);
   endtask

   task automatic chk_drained(input string name);
      chk(name, sb.size(), 0);
   endtask

   initial begin
      int t0;
      int t1;
      int p0;
      logic [6:0] bounce;
      total = 0;
      bad   = 0;
      pulses = 0;
      fork
         monitor();
      join_none

      // Both buttons held through reset: fresh press after deassertion.
      reset        = 1'b1;
      bus.up       = 1'b1;
      bus.down     = 1'b1;
      bus.jump_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk_outs("held_reset", 0, 0, 0, 0);
      end
      reset = 1'b0;
      t0 = edge_cnt;
      expect_pulse(t0 + 6, 1);
      step(1);
      chk_outs("first_after_reset", 0, 0, 0, 0);
      step(4);
      chk("pre_pulse", int'(bus.jump_pulse), 0);
      step(1);
      chk("held_io_jump", int'(bus.io_jump), 1);
      chk("held_count", int'(bus.jump_count), 1);
      step(1);
      chk("held_duck_priority", int'(bus.duck), 0);
      chk_drained("held_drained");

      // Clean press, request latched until acknowledged.
      do_reset();
      t0 = edge_cnt;
      bus.up = 1'b1;
      expect_pulse(t0 + 6, 1);
      step(5);
      chk("clean_io_jump_early", int'(bus.io_jump), 0);
      step(1);
      chk("clean_io_jump_set", int'(bus.io_jump), 1);
      step(6);
      chk("clean_io_jump_hold", int'(bus.io_jump), 1);
      bus.jump_ack = 1'b1;
      step(1);
      chk("clean_io_jump_clear", int'(bus.io_jump), 0);
      bus.jump_ack = 1'b0;
      step(7);
      bus.up = 1'b0;
      step(10);
      chk("clean_count", int'(bus.jump_count), 1);
      chk_drained("clean_drained");

      // Bounce shorter than the debounce window.
      do_reset();
      bounce = 7'b0110111;
      for (int i = 0; i < 7; i++) begin
         bus.up = bounce[i];
         step(1);
         chk("bounce_io_jump", int'(bus.io_jump), 0);
      end
      bus.up = 1'b0;
      step(10);
      chk("bounce_count", int'(bus.jump_count), 0);
      chk_drained("bounce_drained");

      // Second press strobes in the same cycle that jump_ack is sampled.
      do_reset();
      t0 = edge_cnt;
      bus.up = 1'b1;
      expect_pulse(t0 + 6, 1);
      step(8);
      bus.up = 1'b0;
      step(8);
      t1 = edge_cnt;
      bus.up = 1'b1;
      expect_pulse(t1 + 6, 2);
      step(5);
      chk("coinc_io_jump_before", int'(bus.io_jump), 1);
      bus.jump_ack = 1'b1;
      step(1);
      bus.jump_ack = 1'b0;
      chk("coinc_set_wins", int'(bus.io_jump), 1);
      chk("coinc_count", int'(bus.jump_count), 2);
      step(1);
      chk("coinc_io_jump_after", int'(bus.io_jump), 1);
      bus.up = 1'b0;
      bus.jump_ack = 1'b1;
      step(1);
      chk("coinc_ack_clear", int'(bus.io_jump), 0);
      step(2);
      chk("idle_ack_ignored", int'(bus.io_jump), 0);
      chk("idle_ack_count", int'(bus.jump_count), 2);
      bus.jump_ack = 1'b0;
      step(8);
      chk_drained("coinc_drained");

      // Duck follows down, but jump takes priority.
      do_reset();
      t0 = edge_cnt;
      bus.down = 1'b1;
      step(6);
      chk("duck_not_yet", int'(bus.duck), 0);
      step(1);
      chk("duck_on", int'(bus.duck), 1);
      step(3);
      t1 = edge_cnt;
      bus.up = 1'b1;
      expect_pulse(t1 + 6, 1);
      step(6);
      chk("duck_at_up_stable", int'(bus.duck), 1);
      step(1);
      chk("duck_suppressed", int'(bus.duck), 0);
      step(3);
      bus.up = 1'b0;
      step(6);
      chk("duck_still_off", int'(bus.duck), 0);
      step(1);
      chk("duck_restored", int'(bus.duck), 1);
      bus.down = 1'b0;
      step(8);
      chk_drained("duck_drained");

      // Reset in the middle of a debounce leaves nothing behind.
      do_reset();
      bus.up = 1'b1;
      step(4);
      reset  = 1'b1;
      bus.up = 1'b0;
      step(2);
      chk_outs("abort_reset", 0, 0, 0, 0);
      reset = 1'b0;
      step(12);
      chk_outs("abort_after", 0, 0, 0, 0);

      // 256 presses wrap the counter back to zero.
      do_reset();
      p0 = pulses;
      for (int k = 0; k < 256; k++) begin
         bus.up = 1'b1;
         expect_pulse(edge_cnt + 6, (k + 1) % 256);
         step(8);
         bus.up = 1'b0;
         step(8);
      end
      chk("wrap_pulses", pulses - p0, 256);
      chk("wrap_count", int'(bus.jump_count), 0);
      chk("wrap_io_jump", int'(bus.io_jump), 1);
      chk_drained("wrap_drained");

      // A pending request does not survive reset.
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001: Parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive cycles a synchronized input must differ from its stable value before the stable value flips; legal range 2..2^20.
REQ-002: clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004: up  input  1  raw, asynchronous, bouncing jump button.
REQ-005: down  input  1  raw, asynchronous, bouncing duck button.
REQ-006: jump_ack  input  1  processor acknowledge; high for one or more cycles once the jump request has been consumed.
REQ-007: io_jump  output  1  registered jump request level, fed to the processor io_jump port.
REQ-008: jump_pulse  output  1  registered one-cycle strobe on each debounced up press, fed to the VGA controller.
REQ-009: duck  output  1  registered debounced down level, forced low while debounced up is high.
REQ-010: jump_count  output  8  registered count of debounced up presses, used as a debug and score aid.

Function
REQ-011: Each raw input SHALL pass through a two-flop synchronizer, and only the second flop (x_sync) SHALL be used downstream.
REQ-012: Each button SHALL run a separate four-state FSM: LOW_STABLE, RISE_WAIT, HIGH_STABLE, FALL_WAIT.
REQ-013: In LOW_STABLE, x_sync=1 SHALL move the FSM to RISE_WAIT with counter=1.
REQ-014: In RISE_WAIT, x_sync=0 SHALL return the FSM to LOW_STABLE with counter=0, and x_sync=1 SHALL increment the counter; when the counter reaches DEBOUNCE_CYCLES the FSM SHALL move to HIGH_STABLE and clear the counter.
REQ-015: HIGH_STABLE and FALL_WAIT SHALL mirror REQ-013 and REQ-014 with polarity inverted.
REQ-016: The debounced level x_stable SHALL be 1 exactly in HIGH_STABLE and FALL_WAIT.
REQ-017: Latency from a clean raw edge to the x_stable change SHALL be exactly 2+DEBOUNCE_CYCLES rising edges.
REQ-018: Any pulse on x_sync lasting fewer than DEBOUNCE_CYCLES cycles SHALL produce no x_stable change.
REQ-019: The debounce counter SHALL be 20 bits wide and SHALL never exceed DEBOUNCE_CYCLES.
REQ-020: jump_pulse SHALL be 1 for exactly the one cycle in which up_stable first reads 1 after reading 0, and 0 otherwise.
REQ-021: io_jump SHALL be set on the same edge that asserts jump_pulse.
REQ-022: io_jump SHALL clear on the edge after jump_ack is sampled high while no press is occurring.
REQ-023: When a new press and jump_ack occur in the same cycle, set SHALL win and io_jump SHALL remain 1.
REQ-024: jump_ack sampled while io_jump=0 SHALL be ignored.
REQ-025: Repeated presses while io_jump=1 SHALL keep io_jump at 1 and SHALL still pulse jump_pulse and increment jump_count.
REQ-026: jump_count SHALL increment by 1 on each jump_pulse edge and SHALL wrap from 255 to 0 without saturation.
REQ-027: duck SHALL equal down_stable AND NOT up_stable, registered, so that jump has priority.
REQ-028: jump_pulse, io_jump, duck and jump_count SHALL be driven directly from flops with no combinational path from any input.

Reset
REQ-029: While reset is high, all synchronizer flops, FSMs (set to LOW_STABLE), counters, io_jump, jump_pulse, duck and jump_count SHALL go to 0 on the clock edge.
REQ-030: Reset asserted mid-debounce or mid-request SHALL abort all activity, so that no pulse or request survives reset.
REQ-031: A button held high through reset deassertion SHALL be treated as a fresh press, producing a pulse 2+DEBOUNCE_CYCLES edges later.
REQ-032: Outputs SHALL be 0 in the first cycle after reset deasserts.

Verification (DEBOUNCE_CYCLES=4)
REQ-033: Scenario: reset for 3 cycles with up=1 and down=1 -> all outputs 0 during reset; after deassertion jump_pulse=1 exactly at edge 6 and jump_count=1.
REQ-034: Scenario: up rises cleanly at edge 0 and is held 20 cycles -> jump_pulse high only at edge 6, io_jump=1 from edge 6 and held until jump_ack; jump_ack at edge 12 -> io_jump=0 at edge 13.
REQ-035: Scenario: up bounces 1,1,1,0,1,1,0 then holds 0 -> jump_pulse, io_jump and jump_count stay 0 throughout.
REQ-036: Scenario: second press timed so that its jump_pulse coincides with jump_ack -> io_jump stays 1 and jump_count increments to 2.
REQ-037: Scenario: down held, then up held -> duck=1 after debounce, duck=0 the cycle after up_stable=1, and duck=1 again after up is released and debounced.
REQ-038: Scenario: 256 clean presses -> jump_count returns to 0 and 256 single-cycle jump_pulses are counted.
